bus_rr_interconnect: RTL and testbench
======================================

Name: bus_rr_interconnect

Overview:
- Parametrised N-master to 1-slave Avalon-MM interconnect. It is the next generation of the arbiter-plus-mux interconnect.
- Adds configurable data and address widths, registered round-robin arbitration and grant hold across back-to-back transfers with a fairness cap.
- Sits in front of each slave port of the SOC bus. It passes a master's transfer only when that master's address select field matches this slave.

Parameters:
- NUM_INPUTS, 2, number of Avalon masters (1..16).
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- ADDR_WIDTH, 30, word address width.
- SEL_NUM_BITS, 5, number of address MSBs used for slave select.
- SEL_VAL, 0, select value that addresses this slave.
- MAX_TRANSFERS, 4, consecutive transfers one master may complete before grant must rotate (>=1).

Ports:
- i_Clk  in  1  clock; all state changes on rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_AVIn_Addr  in  ADDR_WIDTH*NUM_INPUTS  packed master addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_AVIn_ByteEn  in  (DATA_WIDTH/8)*NUM_INPUTS  packed byte enables.
- i_AVIn_Read  in  NUM_INPUTS  read strobes.
- i_AVIn_Write  in  NUM_INPUTS  write strobes.
- i_AVIn_WriteData  in  DATA_WIDTH*NUM_INPUTS  packed write data.
- o_AVIn_ReadData  out  DATA_WIDTH*NUM_INPUTS  packed read data.
- o_AVIn_WaitRequest  out  NUM_INPUTS  per-master wait request.
- o_AVOut_Addr  out  ADDR_WIDTH  slave address.
- o_AVOut_ByteEn  out  DATA_WIDTH/8  slave byte enables.
- o_AVOut_Read  out  1  slave read.
- o_AVOut_Write  out  1  slave write.
- i_AVOut_ReadData  in  DATA_WIDTH  slave read data.
- o_AVOut_WriteData  out  DATA_WIDTH  slave write data.
- i_AVOut_WaitRequest  in  1  slave wait request.

Behaviour:
- Request: req[k] = (Read[k] | Write[k]) & (Addr_k[ADDR_WIDTH-1 -: SEL_NUM_BITS] == SEL_VAL).
- Read and Write both high on one master: treated as one request; both strobes are forwarded unchanged.
- State registers:
  - state: IDLE or GRANT.
  - grant index, $clog2(NUM_INPUTS) bits.
  - last_grant, same width.
  - xfer_cnt, $clog2(MAX_TRANSFERS+1) bits.
- Reset (async assert, sync release): state=IDLE, grant=0, last_grant=NUM_INPUTS-1 so master 0 has first priority, xfer_cnt=0.
- Output values during reset and IDLE:
  - All o_AVOut_* = 0.
  - o_AVIn_ReadData = 0.
  - o_AVIn_WaitRequest[k] = req[k].
- IDLE:
  - If any req, pick the first requesting index scanning last_grant+1, last_grant+2, ... modulo NUM_INPUTS.
  - Next edge: grant=pick, state=GRANT, xfer_cnt=0.
  - No req: stay IDLE.
- GRANT (grant=g): datapath is combinational.
  - o_AVOut_Addr/ByteEn/WriteData = master g fields.
  - o_AVOut_Read = Read[g] & req[g]; o_AVOut_Write = Write[g] & req[g].
  - Master g: WaitRequest = i_AVOut_WaitRequest when req[g], else 0; ReadData = i_AVOut_ReadData.
  - Master k≠g: WaitRequest = req[k]; ReadData = 0 (zero so outputs can be OR-combined across slaves).
- Transfer completes in a cycle where state=GRANT, req[g]=1 and i_AVOut_WaitRequest=0. At that edge:
  - xfer_cnt+1 == MAX_TRANSFERS: state=IDLE, last_grant=g, xfer_cnt=0.
  - Otherwise: stay GRANT, xfer_cnt+1.
- req[g]=0 in GRANT (master idle or addressing another slave): at next edge state=IDLE, last_grant=g, xfer_cnt=0.
- Latency: one arbitration cycle. A request first seen in IDLE always gets WaitRequest=1 for at least one cycle. A held grant allows zero-wait back-to-back transfers.
- Slave stalls (i_AVOut_WaitRequest=1): grant held indefinitely; no timeout.
- Simultaneous requests: strict round-robin. Each master waits at most (NUM_INPUTS-1) grants of MAX_TRANSFERS transfers.
- NUM_INPUTS=1: grant is always 0; the arbitration cycle is still present.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous); the in-flight transfer is abandoned.

Test Plan:
- Single read, NUM_INPUTS=2, master 0 addr 0x0000_0100 (SEL_VAL=0), slave WaitRequest=0 → cycle 0 o_AVIn_WaitRequest[0]=1 and o_AVOut_Read=0; cycle 1 o_AVOut_Read=1, Addr=0x100, master 0 gets slave data 0xDEADBEEF with WaitRequest=0.
- Both masters read continuously, MAX_TRANSFERS=4 → grant sequence 4 transfers m0, one IDLE cycle, 4 transfers m1, one IDLE cycle, repeat; master 1 WaitRequest=1 and ReadData=0 throughout m0 bursts.
- Master 1 writes to addr with top 5 bits = 5'h03 (not SEL_VAL) → no grant, o_AVOut_Write stays 0, o_AVIn_WaitRequest[1]=0.
- Slave holds WaitRequest=1 for 3 cycles on m0 write 0x12345678 ByteEn 4'b0011 → m0 WaitRequest=1 for those 3 cycles; Addr/WriteData/ByteEn stable; completion on cycle 4; xfer_cnt=1.
- Master 0 drops Read after 2 transfers while master 1 requests → next edge IDLE with last_grant=0, following edge grant=1.
- i_Rst_n pulsed low mid-GRANT with slave stalled → o_AVOut_Read/Write=0 within the same cycle; after release master 0 has first priority.

Source files
------------

// File: rtl/bus_rr_interconnect.sv
// N-master to 1-slave Avalon-MM interconnect with registered round-robin arbitration.
// A granted master keeps the slave for up to MAX_TRANSFERS back-to-back transfers,
// then the grant returns to IDLE for one arbitration cycle and rotates.
module bus_rr_interconnect #(
  parameter int unsigned NUM_INPUTS    = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned SEL_NUM_BITS  = 5,
  parameter int unsigned SEL_VAL       = 0,
  parameter int unsigned MAX_TRANSFERS = 4
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_n,
  input  logic [ADDR_WIDTH*NUM_INPUTS-1:0]      i_AVIn_Addr,
  input  logic [(DATA_WIDTH/8)*NUM_INPUTS-1:0]  i_AVIn_ByteEn,
  input  logic [NUM_INPUTS-1:0]                 i_AVIn_Read,
  input  logic [NUM_INPUTS-1:0]                 i_AVIn_Write,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]      i_AVIn_WriteData,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0]      o_AVIn_ReadData,
  output logic [NUM_INPUTS-1:0]                 o_AVIn_WaitRequest,
  output logic [ADDR_WIDTH-1:0]                 o_AVOut_Addr,
  output logic [DATA_WIDTH/8-1:0]               o_AVOut_ByteEn,
  output logic                                  o_AVOut_Read,
  output logic                                  o_AVOut_Write,
  input  logic [DATA_WIDTH-1:0]                 i_AVOut_ReadData,
  output logic [DATA_WIDTH-1:0]                 o_AVOut_WriteData,
  input  logic                                  i_AVOut_WaitRequest
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned IdxW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned CntW    = $clog2(MAX_TRANSFERS + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic [CntW-1:0]       xfer_cnt_q, xfer_cnt_d;
  logic [NUM_INPUTS-1:0] req;
  logic [IdxW-1:0]       pick;
  logic                  pick_found;
  logic                  grant_req;

  // Decode per-master requests: strobe active and select field addresses this slave
  always_comb begin
    req = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      req[k] = (i_AVIn_Read[k] | i_AVIn_Write[k]) &
               (i_AVIn_Addr[k*ADDR_WIDTH + ADDR_WIDTH - 1 -: SEL_NUM_BITS] ==
                SEL_NUM_BITS'(SEL_VAL));
    end
  end

  // Round-robin pick: first requester after last_grant, wrapping modulo NUM_INPUTS
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_INPUTS; i++) begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        if (!pick_found && req[k] && (k == (32'(last_grant_q) + i) % NUM_INPUTS)) begin
          pick_found = 1'b1;
          pick       = IdxW'(k);
        end
      end
    end
  end

  // Datapath mux: granted master drives the slave, everyone else sees wait and zero data
  always_comb begin
    o_AVOut_Addr       = '0;
    o_AVOut_ByteEn     = '0;
    o_AVOut_WriteData  = '0;
    o_AVOut_Read       = 1'b0;
    o_AVOut_Write      = 1'b0;
    o_AVIn_ReadData    = '0;
    o_AVIn_WaitRequest = req;
    grant_req          = 1'b0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (state_q == StGrant && IdxW'(k) == grant_q) begin
        grant_req             = req[k];
        o_AVOut_Addr          = i_AVIn_Addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        o_AVOut_ByteEn        = i_AVIn_ByteEn[k*BeWidth +: BeWidth];
        o_AVOut_WriteData     = i_AVIn_WriteData[k*DATA_WIDTH +: DATA_WIDTH];
        o_AVOut_Read          = i_AVIn_Read[k] & req[k];
        o_AVOut_Write         = i_AVIn_Write[k] & req[k];
        o_AVIn_WaitRequest[k] = req[k] & i_AVOut_WaitRequest;
        o_AVIn_ReadData[k*DATA_WIDTH +: DATA_WIDTH] = i_AVOut_ReadData;
      end
    end
  end

  // Arbitration FSM next state: grant, hold, and release after the fairness cap
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StGrant;
          grant_d    = pick;
          xfer_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!grant_req) begin
          // Master went idle or moved to another slave: give up the grant
          state_d      = StIdle;
          last_grant_d = grant_q;
          xfer_cnt_d   = '0;
        end else if (!i_AVOut_WaitRequest) begin
          if (xfer_cnt_q + CntW'(1) == CntW'(MAX_TRANSFERS)) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
            xfer_cnt_d   = '0;
          end else begin
            xfer_cnt_d = xfer_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset leaves master 0 with first priority
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(NUM_INPUTS - 1);
      xfer_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_interconnect.sv
// Self-checking bench for bus_rr_interconnect: directed table, hand sequences for
// stalls / early release / reset, and random traffic against a behavioural model.
module tb_bus_rr_interconnect;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SB = 5;
  localparam int SV = 0;
  localparam int MT = 4;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW*N-1:0]   in_addr;
  logic [BW*N-1:0]   in_be;
  logic [N-1:0]      in_rd;
  logic [N-1:0]      in_wr;
  logic [DW*N-1:0]   in_wd;
  logic [DW*N-1:0]   out_rdata;
  logic [N-1:0]      out_wait;
  logic [AW-1:0]     s_addr;
  logic [BW-1:0]     s_be;
  logic              s_rd;
  logic              s_wr;
  logic [DW-1:0]     s_rdata;
  logic [DW-1:0]     s_wd;
  logic              s_wait;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: current owner (-1 = none), transfers served, last owner
  int owner;
  int served;
  int last;

  bus_rr_interconnect #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .SEL_NUM_BITS(SB), .SEL_VAL(SV), .MAX_TRANSFERS(MT)
  ) dut (
    .i_Clk              (clk),
    .i_Rst_n            (rst_n),
    .i_AVIn_Addr        (in_addr),
    .i_AVIn_ByteEn      (in_be),
    .i_AVIn_Read        (in_rd),
    .i_AVIn_Write       (in_wr),
    .i_AVIn_WriteData   (in_wd),
    .o_AVIn_ReadData    (out_rdata),
    .o_AVIn_WaitRequest (out_wait),
    .o_AVOut_Addr       (s_addr),
    .o_AVOut_ByteEn     (s_be),
    .o_AVOut_Read       (s_rd),
    .o_AVOut_Write      (s_wr),
    .i_AVOut_ReadData   (s_rdata),
    .o_AVOut_WriteData  (s_wd),
    .i_AVOut_WaitRequest(s_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd0;
    logic        rd1;
    logic        wr1;
    logic [29:0] a0;
    logic [29:0] a1;
    logic        sw;
    logic [31:0] srd;
    logic [1:0]  e_wait;
    logic        e_rd;
    logic        e_wr;
    logic [29:0] e_addr;
    logic [63:0] e_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] req_of();
    logic [N-1:0] r;
    logic [AW-1:0] a;
    for (int k = 0; k < N; k++) begin
      a = in_addr[k*AW +: AW];
      r[k] = (in_rd[k] | in_wr[k]) && (a[AW-1 -: SB] == SB'(SV));
    end
    return r;
  endfunction

  task automatic model_reset();
    owner  = -1;
    served = 0;
    last   = N - 1;
  endtask

  // Apply the arbitration rules for one rising edge
  task automatic model_edge();
    logic [N-1:0] r;
    bit found;
    int k;
    r = req_of();
    found = 0;
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        k = (last + i) % N;
        if (!found && r[k]) begin
          found  = 1;
          owner  = k;
          served = 0;
        end
      end
    end else if (!r[owner]) begin
      last  = owner;
      owner = -1;
      served = 0;
    end else if (!s_wait) begin
      served++;
      if (served == MT) begin
        last   = owner;
        owner  = -1;
        served = 0;
      end
    end
  endtask

  task automatic model_check();
    logic [N-1:0]    r;
    logic [AW-1:0]   e_addr;
    logic [BW-1:0]   e_be;
    logic [DW-1:0]   e_wd;
    logic            e_rd;
    logic            e_wr;
    logic [N-1:0]    e_wait;
    logic [DW*N-1:0] e_rdata;
    r = req_of();
    e_addr = '0; e_be = '0; e_wd = '0; e_rd = 0; e_wr = 0; e_wait = r; e_rdata = '0;
    if (rst_n && owner >= 0) begin
      e_addr = in_addr[owner*AW +: AW];
      e_be   = in_be[owner*BW +: BW];
      e_wd   = in_wd[owner*DW +: DW];
      e_rd   = in_rd[owner] & r[owner];
      e_wr   = in_wr[owner] & r[owner];
      e_wait[owner] = r[owner] ? s_wait : 1'b0;
      e_rdata[owner*DW +: DW] = s_rdata;
    end
    check("m_addr", 64'(s_addr), 64'(e_addr));
    check("m_byteen", 64'(s_be), 64'(e_be));
    check("m_wdata", 64'(s_wd), 64'(e_wd));
    check("m_read", 64'(s_rd), 64'(e_rd));
    check("m_write", 64'(s_wr), 64'(e_wr));
    check("m_wait", 64'(out_wait), 64'(e_wait));
    check("m_rdata", 64'(out_rdata), 64'(e_rdata));
  endtask

  task automatic set_master(input int k, input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd);
    in_rd[k] = rd;
    in_wr[k] = wr;
    in_addr[k*AW +: AW] = a;
    in_be[k*BW +: BW] = be;
    in_wd[k*DW +: DW] = wd;
  endtask

  task automatic clear_inputs();
    in_addr = '0; in_be = '0; in_rd = '0; in_wr = '0; in_wd = '0;
    s_rdata = '0; s_wait = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Synchronous release of a reset pulse; ends just after a rising edge
  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
  endtask

  vec_t vecs[7];
  int   exp_owner;

  initial begin
    clear_inputs();
    model_reset();
    vecs[0] = '{1, 0, 0, 30'h100, 30'h0, 0, 32'hDEADBEEF, 2'b01, 0, 0, 30'h0, 64'h0};
    vecs[1] = '{1, 0, 0, 30'h100, 30'h0, 0, 32'hDEADBEEF, 2'b00, 1, 0, 30'h100,
                64'h0000_0000_DEAD_BEEF};
    vecs[2] = '{0, 0, 0, 30'h0, 30'h0, 0, 32'hDEADBEEF, 2'b00, 0, 0, 30'h0,
                64'h0000_0000_DEAD_BEEF};
    vecs[3] = '{0, 0, 1, 30'h0, 30'h0600_0000, 0, 32'hCAFEF00D, 2'b00, 0, 0, 30'h0, 64'h0};
    vecs[4] = '{1, 1, 0, 30'h100, 30'h200, 0, 32'hCAFEF00D, 2'b11, 0, 0, 30'h0, 64'h0};
    vecs[5] = '{1, 1, 0, 30'h100, 30'h200, 0, 32'hCAFEF00D, 2'b01, 1, 0, 30'h200,
                64'hCAFE_F00D_0000_0000};
    vecs[6] = '{1, 1, 1, 30'h100, 30'h200, 0, 32'hCAFEF00D, 2'b01, 1, 1, 30'h200,
                64'hCAFE_F00D_0000_0000};

    // Outputs while reset is held, with and without a pending request
    repeat (2) @(posedge clk);
    #1;
    check("rst_wait_idle", 64'(out_wait), 64'h0);
    check("rst_read_idle", 64'(s_rd), 64'h0);
    set_master(0, 1, 0, 30'h100, '0, '0);
    #1;
    check("rst_wait_req", 64'(out_wait), 64'b01);
    check("rst_read_req", 64'(s_rd), 64'h0);
    check("rst_addr_req", 64'(s_addr), 64'h0);

    // Directed table
    do_reset();
    foreach (vecs[i]) begin
      set_master(0, vecs[i].rd0, 0, vecs[i].a0, '0, '0);
      set_master(1, vecs[i].rd1, vecs[i].wr1, vecs[i].a1, '0, '0);
      s_wait = vecs[i].sw;
      s_rdata = vecs[i].srd;
      @(negedge clk);
      check($sformatf("tbl%0d_wait", i), 64'(out_wait), 64'(vecs[i].e_wait));
      check($sformatf("tbl%0d_read", i), 64'(s_rd), 64'(vecs[i].e_rd));
      check($sformatf("tbl%0d_write", i), 64'(s_wr), 64'(vecs[i].e_wr));
      check($sformatf("tbl%0d_addr", i), 64'(s_addr), 64'(vecs[i].e_addr));
      check($sformatf("tbl%0d_rdata", i), 64'(out_rdata), vecs[i].e_rdata);
      model_check();
      advance();
    end

    // Slave stall: three wait cycles, then completion counts as one transfer
    do_reset();
    set_master(0, 0, 1, 30'h40, 4'b0011, 32'h12345678);
    s_wait = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c == 4) s_wait = 1'b0;
      @(negedge clk);
      if (c == 0 || c == 8) begin
        check($sformatf("stall%0d_wait", c), 64'(out_wait), 64'b01);
        check($sformatf("stall%0d_write", c), 64'(s_wr), 64'h0);
      end else begin
        check($sformatf("stall%0d_wait", c), 64'(out_wait), (c < 4) ? 64'b01 : 64'b00);
        check($sformatf("stall%0d_write", c), 64'(s_wr), 64'h1);
        check($sformatf("stall%0d_bus", c), {s_addr[19:0], s_be, s_wd},
              {20'h40, 4'b0011, 32'h12345678, 8'h0} >> 8);
      end
      model_check();
      advance();
    end

    // Master 0 drops after two transfers while master 1 waits
    do_reset();
    set_master(0, 1, 0, 30'h100, '0, '0);
    set_master(1, 1, 0, 30'h200, '0, '0);
    for (int c = 0; c <= 5; c++) begin
      if (c == 3) in_rd[0] = 1'b0;
      @(negedge clk);
      unique case (c)
        0:       check("drop0_wait", 64'(out_wait), 64'b11);
        1, 2:    check($sformatf("drop%0d_wait", c), 64'(out_wait), 64'b10);
        3, 4: begin
          check($sformatf("drop%0d_wait", c), 64'(out_wait), 64'b10);
          check($sformatf("drop%0d_read", c), 64'(s_rd), 64'h0);
        end
        default: begin
          check("drop5_wait", 64'(out_wait), 64'b00);
          check("drop5_addr", 64'(s_addr), 64'h200);
        end
      endcase
      model_check();
      advance();
    end

    // Both masters saturating: 4 x m0, idle, 4 x m1, idle, ...
    do_reset();
    set_master(0, 1, 0, 30'h100, 4'hF, 32'h1111_1111);
    set_master(1, 1, 0, 30'h200, 4'hF, 32'h2222_2222);
    s_rdata = 32'h5A5A_5A5A;
    for (int c = 0; c < 20; c++) begin
      exp_owner = ((c % 10) == 0 || (c % 10) == 5) ? -1 : ((c % 10) < 5 ? 0 : 1);
      @(negedge clk);
      check($sformatf("rr%0d_wait", c), 64'(out_wait),
            (exp_owner < 0) ? 64'b11 : (exp_owner == 0 ? 64'b10 : 64'b01));
      check($sformatf("rr%0d_addr", c), 64'(s_addr),
            (exp_owner < 0) ? 64'h0 : (exp_owner == 0 ? 64'h100 : 64'h200));
      model_check();
      advance();
    end

    // Reset pulse mid-grant with slave stalled
    do_reset();
    set_master(0, 1, 0, 30'h100, '0, '0);
    s_wait = 1'b1;
    advance();
    @(negedge clk);
    check("rstmid_read_before", 64'(s_rd), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_read", 64'(s_rd), 64'h0);
    check("rstmid_write", 64'(s_wr), 64'h0);
    check("rstmid_wait", 64'(out_wait), 64'b01);
    model_reset();
    set_master(1, 1, 0, 30'h200, '0, '0);
    s_wait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    @(negedge clk);
    check("rstmid_prio_wait", 64'(out_wait), 64'b10);
    check("rstmid_prio_addr", 64'(s_addr), 64'h100);
    model_check();
    advance();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        logic [AW-1:0] a;
        a = AW'($urandom);
        a[AW-1 -: SB] = ($urandom_range(0, 3) != 0) ? SB'(SV) : SB'($urandom_range(1, 31));
        set_master(k, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), a,
                   BW'($urandom), DW'($urandom));
      end
      s_wait  = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      model_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
